ysyx_rf_wb_arbiter: RTL and testbench
=====================================

Name: ysyx_rf_wb_arbiter

Overview:
- Sequences all writes into the single write port of the 32x32 integer register file.
- Arbitrates between the EX (ALU/CSR result) writeback source and the LSU (load return) writeback source.
- Registers the winning write onto the RF port and keeps a per-register pending scoreboard, which issue logic queries for RAW/WAW hazards.
- Sits between the EX/LSU stages and the register file in the NPC core.

Parameters:
- NREG, 32, number of architectural registers; x0 is hardwired to zero.
- AW, 5, register index width; must equal log2(NREG).
- DW, 32, data width.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the clk rising edge.
- ex_valid  in  1  EX writeback request.
- ex_ready  out  1  EX request accepted this cycle.
- ex_rd  in  AW  EX destination register.
- ex_data  in  DW  EX result.
- lsu_valid  in  1  LSU writeback request.
- lsu_ready  out  1  LSU request accepted this cycle.
- lsu_rd  in  AW  LSU destination register.
- lsu_data  in  DW  load data.
- issue_valid  in  1  decode issuing an instruction that writes issue_rd.
- issue_rd  in  AW  destination of the issuing instruction.
- issue_ready  out  1  issue permitted (no WAW conflict).
- chk_rs1, chk_rs2  in  AW  source registers to check.
- rs1_busy, rs2_busy  out  1  source register has a pending write.
- rf_wr_en  out  1  RF write enable.
- rf_waddr  out  AW  RF write address.
- rf_wdata  out  DW  RF write data.

Behaviour:
- Reset (rst_n=0 at an edge):
  - rf_wr_en=0, rf_waddr=0, rf_wdata=0.
  - pending[NREG-1:0]=0.
  - last_grant=EX, so LSU wins the first conflict.
- While rst_n=0, ex_ready, lsu_ready and issue_ready are forced to 0 combinationally.
- Reset mid-operation drops any write being presented on the RF port (rf_wr_en is 0 the next cycle) and clears all pending bits.
- Arbitration is combinational and valid/ready style. Acceptance means valid&&ready at an edge.
  - Only one source valid: it is granted and its ready=1.
  - Both valid: round-robin. Grant goes to the source not equal to last_grant. last_grant updates only on a conflict grant.
  - The loser holds valid with stable rd/data. It wins the next cycle if still requesting.
  - ready never depends on the loser's own valid; no combinational loop from ready back into valid.
- Output register, latency 1:
  - A write accepted at edge N drives rf_wr_en=1 with the registered rd/data throughout cycle N+1. The RF captures it at edge N+1.
  - Back-to-back accepts give one RF write per cycle. There is no internal queue, and the output register never back-pressures.
- rd==0 writes are accepted (ready=1) but produce rf_wr_en=0 and have no scoreboard effect.
- Scoreboard:
  - issue_ready = rst_n && !(issue_rd!=0 && pending[issue_rd]). This blocks WAW.
  - issue_valid&&issue_ready with issue_rd!=0 sets pending[issue_rd] at that edge.
  - pending[rf_waddr] clears at the edge that ends a cycle with rf_wr_en=1, i.e. when the RF actually takes the data.
  - Set and clear of the same register on the same edge: set wins.
  - rs1_busy = chk_rs1!=0 && pending[chk_rs1]; rs2_busy likewise. Both are combinational from current state.
  - A register is therefore busy through the cycle its RF write is presented. Readers see the new value from the following cycle.
- A writeback to a register whose pending bit is already clear is still written. Its clear is a no-op. No error is raised.

Optional Feature:
- Macro: YSYX_RF_ARB_TRACE_EN.
- Defined: on every RF commit (rf_wr_en=1 at an edge), a simulation $display prints the cycle count, "x<rd> <= <hex data>" and the source (EX/LSU, tracked in a 1-bit registered src flag).
  - Also prints "ARB CONFLICT" on each conflict grant.
  - The cycle counter and src flag exist only under the macro.
- Undefined: no display statements, counter or src flag. Logic is otherwise identical.

Test Plan:
- Reset: hold rst_n=0 3 cycles with ex_valid=1 -> ex_ready=0, rf_wr_en=0 and issue_ready=0 throughout. After release, pending=0 and rs1_busy=0 for all indices.
- Single EX write: issue x5, then ex_valid with rd=5, data=0xDEADBEEF.
  - Accepted at edge N -> rf_wr_en=1, waddr=5, wdata=0xDEADBEEF in cycle N+1.
  - rs1_busy(chk_rs1=5)=1 until edge N+1, then 0.
- Conflict round-robin: both valid every cycle (EX rd=3 data=0x11, LSU rd=4 data=0x22) -> grants LSU, EX, LSU, EX. The loser's ready=0 on its losing cycle.
- x0: ex_valid rd=0 data=0xFFFF -> ex_ready=1, rf_wr_en stays 0. issue rd=0 -> issue_ready=1, no pending bit set.
- WAW/same-edge: pending[7]=1, issue rd=7 -> issue_ready=0.
  - In the cycle rf_wr_en=1 for x7: issue_ready is still 0.
  - Next cycle: issue_ready=1 and the issue sets pending[7] again.
  - Separately, a set and clear of x9 on the same edge leaves pending[9]=1.
- Reset mid-write: assert rst_n=0 in the cycle after an accept -> next cycle rf_wr_en=0 and pending all 0.

Source files
------------

// File: rtl/ysyx_rf_wb_arbiter.sv
// Register-file writeback arbiter: round-robin EX/LSU merge onto the single RF write port plus a pending-write scoreboard.
// Optional commit/conflict trace enabled by defining YSYX_RF_ARB_TRACE_EN.
module ysyx_rf_wb_arbiter #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ex_valid,
    output logic          ex_ready,
    input  logic [AW-1:0] ex_rd,
    input  logic [DW-1:0] ex_data,
    input  logic          lsu_valid,
    output logic          lsu_ready,
    input  logic [AW-1:0] lsu_rd,
    input  logic [DW-1:0] lsu_data,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_rd,
    output logic          issue_ready,
    input  logic [AW-1:0] chk_rs1,
    input  logic [AW-1:0] chk_rs2,
    output logic          rs1_busy,
    output logic          rs2_busy,
    output logic          rf_wr_en,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata
);

    typedef enum logic {SRC_EX = 1'b0, SRC_LSU = 1'b1} src_e;

    src_e            r_last_grant;
    logic            r_wr_en;
    logic [AW-1:0]   r_waddr;
    logic [DW-1:0]   r_wdata;
    logic [NREG-1:0] r_pending;

    logic            w_conflict;
    logic            w_ex_acc;
    logic            w_lsu_acc;
    logic            w_issue_acc;
    logic [NREG-1:0] w_pending_nxt;

    // Each ready depends only on the other source's valid, so no ready->valid loop exists.
    assign w_conflict  = ex_valid && lsu_valid;
    assign ex_ready    = rst_n && (!lsu_valid || (r_last_grant == SRC_LSU));
    assign lsu_ready   = rst_n && (!ex_valid || (r_last_grant == SRC_EX));
    assign w_ex_acc    = ex_valid && ex_ready;
    assign w_lsu_acc   = lsu_valid && lsu_ready;

    assign issue_ready = rst_n && !((issue_rd != '0) && r_pending[issue_rd]);
    assign w_issue_acc = issue_valid && issue_ready && (issue_rd != '0);

    assign rs1_busy    = (chk_rs1 != '0) && r_pending[chk_rs1];
    assign rs2_busy    = (chk_rs2 != '0) && r_pending[chk_rs2];

    assign rf_wr_en    = r_wr_en;
    assign rf_waddr    = r_waddr;
    assign rf_wdata    = r_wdata;

    // Clear for the write leaving the RF port first, so a same-edge issue set wins.
    always_comb begin
        w_pending_nxt = r_pending;
        if (r_wr_en) begin
            w_pending_nxt[r_waddr] = 1'b0;
        end
        if (w_issue_acc) begin
            w_pending_nxt[issue_rd] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_grant <= SRC_EX;
            r_wr_en      <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_pending    <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_conflict) begin
                r_last_grant <= w_lsu_acc ? SRC_LSU : SRC_EX;
            end
            // x0 writes are consumed here but never reach the RF.
            if (w_ex_acc) begin
                r_wr_en <= (ex_rd != '0);
                r_waddr <= ex_rd;
                r_wdata <= ex_data;
            end else if (w_lsu_acc) begin
                r_wr_en <= (lsu_rd != '0);
                r_waddr <= lsu_rd;
                r_wdata <= lsu_data;
            end else begin
                r_wr_en <= 1'b0;
            end
        end
    end

`ifdef YSYX_RF_ARB_TRACE_EN
    logic [31:0] r_cycle;
    src_e        r_src;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cycle <= '0;
            r_src   <= SRC_EX;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_ex_acc) begin
                r_src <= SRC_EX;
            end else if (w_lsu_acc) begin
                r_src <= SRC_LSU;
            end
            if (r_wr_en) begin
                $display("[%0d] x%0d <= %08h (%s)", r_cycle, r_waddr, r_wdata,
                         (r_src == SRC_LSU) ? "LSU" : "EX");
            end
            if (w_conflict) begin
                $display("[%0d] ARB CONFLICT -> %s", r_cycle, w_lsu_acc ? "LSU" : "EX");
            end
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_rf_wb_arbiter.sv
// Scoreboard bench for ysyx_rf_wb_arbiter: stimulus queues expected RF writes, a negedge monitor pops and compares them.
module tb_ysyx_rf_wb_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ex_valid, ex_ready;
    logic [AW-1:0] ex_rd;
    logic [DW-1:0] ex_data;
    logic          lsu_valid, lsu_ready;
    logic [AW-1:0] lsu_rd;
    logic [DW-1:0] lsu_data;
    logic          issue_valid, issue_ready;
    logic [AW-1:0] issue_rd;
    logic [AW-1:0] chk_rs1, chk_rs2;
    logic          rs1_busy, rs2_busy;
    logic          rf_wr_en;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;

    int n_tests = 0;
    int n_fail  = 0;
    logic [AW+DW-1:0] exp_q[$];

    ysyx_rf_wb_arbiter #(.NREG(32), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_data(ex_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rf_wr_en(rf_wr_en), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    always #20 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_no_pending(input string name);
        for (int i = 0; i < 16; i++) begin
            chk_rs1 = AW'(i);
            chk_rs2 = AW'(i + 16);
            #1;
            chk({name, "_rs1"}, {63'd0, rs1_busy}, 64'd0);
            chk({name, "_rs2"}, {63'd0, rs2_busy}, 64'd0);
        end
    endtask

    // Monitor: every presented RF write must match the oldest expected write.
    always @(negedge clk) begin
        if (rf_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {59'd0, rf_waddr}, 64'hFFFF);
            end else begin
                logic [AW+DW-1:0] e;
                e = exp_q.pop_front();
                chk("wb_addr", {59'd0, rf_waddr}, {59'd0, e[AW+DW-1:DW]});
                chk("wb_data", {32'd0, rf_wdata}, {32'd0, e[DW-1:0]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        ex_valid = 1'b1; ex_rd = 5'd1; ex_data = 32'h1;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        issue_valid = 1'b0; issue_rd = '0;
        chk_rs1 = '0; chk_rs2 = '0;

        // Reset held 3 cycles with a pending EX request
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_ex_ready", {63'd0, ex_ready}, 64'd0);
            chk("rst_issue_ready", {63'd0, issue_ready}, 64'd0);
            chk("rst_wr_en", {63'd0, rf_wr_en}, 64'd0);
        end
        rst_n = 1'b1;
        ex_valid = 1'b0;
        check_no_pending("rst_busy");

        // Single EX write to x5
        issue_valid = 1'b1; issue_rd = 5'd5;
        #1 chk("issue5_ready", {63'd0, issue_ready}, 64'd1);
        tick();
        issue_valid = 1'b0;
        chk_rs1 = 5'd5;
        ex_valid = 1'b1; ex_rd = 5'd5; ex_data = 32'hDEADBEEF;
        #1;
        chk("x5_busy_pre", {63'd0, rs1_busy}, 64'd1);
        chk("x5_ex_ready", {63'd0, ex_ready}, 64'd1);
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        tick();
        ex_valid = 1'b0;
        #1;
        chk("x5_wr_en", {63'd0, rf_wr_en}, 64'd1);
        chk("x5_waddr", {59'd0, rf_waddr}, 64'd5);
        chk("x5_wdata", {32'd0, rf_wdata}, 64'hDEADBEEF);
        chk("x5_busy_during", {63'd0, rs1_busy}, 64'd1);
        tick();
        chk("x5_busy_after", {63'd0, rs1_busy}, 64'd0);
        chk("x5_wr_en_after", {63'd0, rf_wr_en}, 64'd0);

        // Conflict: LSU first (last_grant=EX after reset), then alternating
        ex_valid = 1'b1; ex_rd = 5'd3; ex_data = 32'h11;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h22;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (k % 2 == 0) begin
                chk("rr_lsu_ready", {63'd0, lsu_ready}, 64'd1);
                chk("rr_ex_ready", {63'd0, ex_ready}, 64'd0);
                exp_q.push_back({5'd4, 32'h22});
            end else begin
                chk("rr_lsu_ready", {63'd0, lsu_ready}, 64'd0);
                chk("rr_ex_ready", {63'd0, ex_ready}, 64'd1);
                exp_q.push_back({5'd3, 32'h11});
            end
            tick();
        end
        ex_valid = 1'b0; lsu_valid = 1'b0;
        tick();

        // x0 writes and issues
        ex_valid = 1'b1; ex_rd = 5'd0; ex_data = 32'hFFFF;
        #1 chk("x0_ex_ready", {63'd0, ex_ready}, 64'd1);
        tick();
        ex_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd0;
        #1;
        chk("x0_wr_en", {63'd0, rf_wr_en}, 64'd0);
        chk("x0_issue_ready", {63'd0, issue_ready}, 64'd1);
        tick();
        issue_valid = 1'b0; chk_rs1 = 5'd0;
        #1 chk("x0_busy", {63'd0, rs1_busy}, 64'd0);

        // WAW on x7
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        #1 chk("waw_blocked", {63'd0, issue_ready}, 64'd0);
        ex_valid = 1'b1; ex_rd = 5'd7; ex_data = 32'h77;
        exp_q.push_back({5'd7, 32'h77});
        tick();
        ex_valid = 1'b0;
        #1;
        chk("waw_wr_en", {63'd0, rf_wr_en}, 64'd1);
        chk("waw_blocked_during", {63'd0, issue_ready}, 64'd0);
        tick();
        chk("waw_ready_after", {63'd0, issue_ready}, 64'd1);
        tick();
        issue_valid = 1'b0; chk_rs1 = 5'd7;
        #1 chk("waw_reissued", {63'd0, rs1_busy}, 64'd1);

        // Same-edge set/clear of x9 (write to non-pending register)
        ex_valid = 1'b1; ex_rd = 5'd9; ex_data = 32'h99;
        exp_q.push_back({5'd9, 32'h99});
        tick();
        ex_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd9;
        #1;
        chk("x9_wr_en", {63'd0, rf_wr_en}, 64'd1);
        chk("x9_issue_ready", {63'd0, issue_ready}, 64'd1);
        tick();
        issue_valid = 1'b0; chk_rs2 = 5'd9;
        #1 chk("x9_set_wins", {63'd0, rs2_busy}, 64'd1);

        // Reset in the cycle after an accept
        ex_valid = 1'b1; ex_rd = 5'd12; ex_data = 32'hC;
        exp_q.push_back({5'd12, 32'hC});
        tick();
        ex_valid = 1'b0; rst_n = 1'b0;
        #1 chk("mid_wr_en_pre", {63'd0, rf_wr_en}, 64'd1);
        tick();
        chk("mid_wr_en_post", {63'd0, rf_wr_en}, 64'd0);
        chk("mid_issue_ready", {63'd0, issue_ready}, 64'd0);
        rst_n = 1'b1;
        check_no_pending("mid_busy");

        // LSU wins the first conflict after reset again
        ex_valid = 1'b1; ex_rd = 5'd3; ex_data = 32'h33;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h44;
        #1;
        chk("post_rst_lsu_ready", {63'd0, lsu_ready}, 64'd1);
        chk("post_rst_ex_ready", {63'd0, ex_ready}, 64'd0);
        exp_q.push_back({5'd4, 32'h44});
        tick();
        ex_valid = 1'b0; lsu_valid = 1'b0;
        tick();
        tick();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
